// File: rtl/sdpb_word_reader.sv
// Read side of the Gowin_SDPB sample buffer: fetches complete 32-bit words
// behind the upstream byte write pointer and presents them as a stereo
// sample pair (left = low half, right = high half) on a valid/ready port.
module sdpb_word_reader (
   input  logic        clk,
   input  logic        rstn,
   input  logic        en,
   input  logic        flush,
   input  logic [9:0]  wr_byte_ptr,
   output logic [6:0]  adb,
   output logic        ceb,
   output logic        oce,
   input  logic [31:0] dout,
   output logic [15:0] out_left,
   output logic [15:0] out_right,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  level,
   output logic        underrun,
   output logic        overflow
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  rd_ptr;
   logic [7:0]  wr_word;
   logic [6:0]  adb_q;
   logic        issue;

   // Only whole words count; the byte offset bits are simply dropped.
   assign wr_word = wr_byte_ptr[9:2];
   assign level   = wr_word - rd_ptr;

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and read-issue decision; flush overrides everything.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (en && (level != 8'd0)) begin
                  issue     = 1'b1;
                  state_nxt = FETCH;
               end
            end
            FETCH: begin
               state_nxt = HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  if (en && (level != 8'd0)) begin
                     issue     = 1'b1;
                     state_nxt = FETCH;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Buffer-side outputs: read strobe only on an issue, address held otherwise.
   always_comb begin
      oce       = 1'b1;
      ceb       = rstn & issue;
      adb       = adb_q;
      out_valid = (state == HOLD);
      if (!rstn) begin
         adb = '0;
      end else if (issue) begin
         adb = rd_ptr[6:0];
      end
   end

   // Read pointer, captured sample pair and sticky status flags.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_ptr    <= '0;
         adb_q     <= '0;
         out_left  <= '0;
         out_right <= '0;
         underrun  <= 1'b0;
         overflow  <= 1'b0;
      end else if (flush) begin
         rd_ptr   <= wr_word;
         underrun <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (issue) begin
            rd_ptr <= rd_ptr + 8'd1;
            adb_q  <= rd_ptr[6:0];
         end
         if (state == FETCH) begin
            out_left  <= dout[15:0];
            out_right <= dout[31:16];
         end
         if (en && out_ready && (state == IDLE) && (level == 8'd0)) begin
            underrun <= 1'b1;
         end
         if (level > 8'd128) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sdpb_word_reader.sv
// Bench for sdpb_word_reader: a byte-addressed buffer model feeds dout, and a
// cycle monitor tracks words issued/delivered in a queue to predict level,
// read strobes, addresses, delivered data, latency and sticky flags.
module tb_sdpb_word_reader;

   logic        clk = 1'b0;
   logic        rstn;
   logic        en;
   logic        flush;
   logic [9:0]  wr_byte_ptr;
   logic [6:0]  adb;
   logic        ceb;
   logic        oce;
   logic [31:0] dout = '0;
   logic [15:0] out_left;
   logic [15:0] out_right;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  level;
   logic        underrun;
   logic        overflow;

   sdpb_word_reader dut (
      .clk         (clk),
      .rstn        (rstn),
      .en          (en),
      .flush       (flush),
      .wr_byte_ptr (wr_byte_ptr),
      .adb         (adb),
      .ceb         (ceb),
      .oce         (oce),
      .dout        (dout),
      .out_left    (out_left),
      .out_right   (out_right),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .level       (level),
      .underrun    (underrun),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Byte-wide view of the 512x8 write side; read side returns little-endian words.
   logic [7:0] mem_b [512];

   always @(posedge clk) begin
      if (ceb) begin
         dout <= {mem_b[{adb, 2'd3}], mem_b[{adb, 2'd2}], mem_b[{adb, 2'd1}], mem_b[{adb, 2'd0}]};
      end
   end

   function automatic logic [31:0] word_at(input logic [6:0] a);
      return {mem_b[{a, 2'd3}], mem_b[{a, 2'd2}], mem_b[{a, 2'd1}], mem_b[{a, 2'd0}]};
   endfunction

   // Reference model state.
   logic        mon_en = 1'b0;
   int          cyc = 0;
   int          last_ceb_cyc = -100;
   logic [6:0]  addr_q [$];
   logic [7:0]  m_rd = '0;
   logic        m_under = 1'b0;
   logic        m_over = 1'b0;
   logic [6:0]  last_adb = '0;
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic        prev_clr = 1'b1;
   logic        prev_rst = 1'b1;
   logic [15:0] prev_l = '0;
   logic [15:0] prev_r = '0;
   logic [15:0] hs_l [$];
   logic [15:0] hs_r [$];
   int          adb_log [$];
   logic [7:0]  m_lvl;
   logic        m_idle;
   logic        m_issue;
   logic [31:0] m_word;

   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         m_lvl  = wr_byte_ptr[9:2] - m_rd;
         m_idle = (addr_q.size() == 0) && !out_valid;
         check("level", {24'd0, level}, {24'd0, m_lvl});
         check("oce", {31'd0, oce}, 32'd1);
         check("underrun", {31'd0, underrun}, {31'd0, m_under});
         check("overflow", {31'd0, overflow}, {31'd0, m_over});
         if (prev_clr) begin
            check("valid_after_clear", {31'd0, out_valid}, 32'd0);
            if (prev_rst) begin
               check("left_after_rst", {16'd0, out_left}, 32'd0);
               check("right_after_rst", {16'd0, out_right}, 32'd0);
            end
         end else if (prev_valid && !prev_ready) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_left", {16'd0, out_left}, {16'd0, prev_l});
            check("hold_right", {16'd0, out_right}, {16'd0, prev_r});
         end
         if (out_valid && !prev_valid && !prev_clr)
            check("latency", cyc - last_ceb_cyc, 32'd2);
         m_issue = rstn && !flush && en && (m_lvl != 8'd0) && (m_idle || (out_valid && out_ready));
         check("ceb", {31'd0, ceb}, {31'd0, m_issue});
         if (!rstn)
            check("adb_rst", {25'd0, adb}, 32'd0);
         else if (m_issue)
            check("adb", {25'd0, adb}, {25'd0, m_rd[6:0]});
         else
            check("adb_hold", {25'd0, adb}, {25'd0, last_adb});
         if (out_valid) begin
            check("valid_has_source", {31'd0, (addr_q.size() != 0)}, 32'd1);
            if (addr_q.size() != 0) begin
               m_word = word_at(addr_q[0]);
               check("left", {16'd0, out_left}, {16'd0, m_word[15:0]});
               check("right", {16'd0, out_right}, {16'd0, m_word[31:16]});
            end
         end
         // Advance the model to what the next edge should produce.
         if (!rstn) begin
            m_rd = '0;
            addr_q.delete();
            m_under  = 1'b0;
            m_over   = 1'b0;
            last_adb = '0;
            prev_clr = 1'b1;
            prev_rst = 1'b1;
         end else if (flush) begin
            m_rd = wr_byte_ptr[9:2];
            addr_q.delete();
            m_under  = 1'b0;
            m_over   = 1'b0;
            prev_clr = 1'b1;
            prev_rst = 1'b0;
         end else begin
            prev_clr = 1'b0;
            prev_rst = 1'b0;
            if (out_valid && out_ready && (addr_q.size() != 0)) begin
               hs_l.push_back(out_left);
               hs_r.push_back(out_right);
               void'(addr_q.pop_front());
            end
            if (m_issue) begin
               addr_q.push_back(m_rd[6:0]);
               adb_log.push_back(int'(adb));
               last_adb     = m_rd[6:0];
               m_rd         = m_rd + 8'd1;
               last_ceb_cyc = cyc;
            end
            if (en && out_ready && m_idle && (m_lvl == 8'd0)) m_under = 1'b1;
            if (m_lvl > 8'd128) m_over = 1'b1;
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_l     = out_left;
         prev_r     = out_right;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      hs_l.delete();
      hs_r.delete();
      adb_log.delete();
   endtask

   task automatic do_flush(input logic [9:0] ptr);
      en          = 1'b0;
      wr_byte_ptr = ptr;
      flush       = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   int wr_tot;
   int budget;

   initial begin
      rstn        = 1'b0;
      en          = 1'b0;
      flush       = 1'b0;
      wr_byte_ptr = '0;
      out_ready   = 1'b0;
      for (int i = 0; i < 512; i++) mem_b[i] = 8'($urandom);
      mem_b[0] = 8'h11;
      mem_b[1] = 8'h22;
      mem_b[2] = 8'h33;
      mem_b[3] = 8'h44;
      repeat (3) tick();
      mon_en = 1'b1;
      tick();
      rstn = 1'b1;
      tick();

      // Two words after reset, free-flowing sink.
      clear_logs();
      wr_byte_ptr = 10'd8;
      en          = 1'b1;
      out_ready   = 1'b1;
      repeat (8) tick();
      check("t1_handshakes", hs_l.size(), 32'd2);
      check("t1_reads", adb_log.size(), 32'd2);
      if (hs_l.size() >= 1) begin
         check("t1_left0", {16'd0, hs_l[0]}, 32'h2211);
         check("t1_right0", {16'd0, hs_r[0]}, 32'h4433);
      end
      if (adb_log.size() >= 2) begin
         check("t1_adb0", adb_log[0], 32'd0);
         check("t1_adb1", adb_log[1], 32'd1);
      end
      check("t1_level", {24'd0, level}, 32'd0);

      // One word held under backpressure.
      do_flush(10'd0);
      clear_logs();
      wr_byte_ptr = 10'd4;
      en          = 1'b1;
      out_ready   = 1'b0;
      repeat (12) tick();
      check("t2_valid", {31'd0, out_valid}, 32'd1);
      check("t2_reads", adb_log.size(), 32'd1);
      check("t2_no_hs", hs_l.size(), 32'd0);
      out_ready = 1'b1;
      tick();
      tick();
      check("t2_hs", hs_l.size(), 32'd1);

      // Partial trailing word is not read; starved sink raises underrun.
      do_flush(10'd0);
      clear_logs();
      wr_byte_ptr = 10'd6;
      en          = 1'b1;
      out_ready   = 1'b1;
      repeat (6) tick();
      check("t3_reads", adb_log.size(), 32'd1);
      check("t3_level", {24'd0, level}, 32'd0);
      check("t3_underrun", {31'd0, underrun}, 32'd1);

      // Overflow above 128 words, cleared by flush.
      do_flush(10'd0);
      wr_byte_ptr = 10'd516;
      repeat (2) tick();
      check("ovf_set", {31'd0, overflow}, 32'd1);
      do_flush(10'd0);
      tick();
      check("ovf_clear", {31'd0, overflow}, 32'd0);

      // 130 words across the address wrap and the 1023->0 byte pointer wrap.
      do_flush(10'd512);
      clear_logs();
      wr_tot = 512;
      budget = 0;
      while ((hs_l.size() < 130) && (budget < 4000)) begin
         if ((wr_tot < 1032) && ((wr_tot - 512 - 4 * hs_l.size()) < 480))
            wr_tot = wr_tot + int'($urandom_range(0, 8));
         if (wr_tot > 1032) wr_tot = 1032;
         wr_byte_ptr = 10'(wr_tot);
         en          = ($urandom_range(0, 4) != 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         tick();
         budget++;
      end
      check("t4_handshakes", hs_l.size(), 32'd130);
      check("t4_reads", adb_log.size(), 32'd130);
      for (int i = 0; i < adb_log.size(); i++)
         check("t4_adb_seq", adb_log[i], i % 128);
      check("t4_overflow", {31'd0, overflow}, 32'd0);
      en        = 1'b1;
      out_ready = 1'b1;
      repeat (3) tick();

      // Flush while a read is in flight.
      wr_byte_ptr = 10'd16;
      en          = 1'b1;
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      en    = 1'b0;
      check("t5_valid", {31'd0, out_valid}, 32'd0);
      check("t5_level", {24'd0, level}, 32'd0);
      check("t5_underrun", {31'd0, underrun}, 32'd0);
      check("t5_overflow", {31'd0, overflow}, 32'd0);
      tick();
      check("t5_valid_stays", {31'd0, out_valid}, 32'd0);

      // Reset while holding a pair.
      wr_byte_ptr = 10'd32;
      en          = 1'b1;
      out_ready   = 1'b0;
      repeat (3) tick();
      check("t6_hold", {31'd0, out_valid}, 32'd1);
      rstn = 1'b0;
      tick();
      check("t6_valid_rst", {31'd0, out_valid}, 32'd0);
      check("t6_left_rst", {16'd0, out_left}, 32'd0);
      en   = 1'b0;
      rstn = 1'b1;
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL timeout: got no end of test expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
